// File: rtl/mips_multicycle_ctrl_if.sv
// Datapath control bundle between the multicycle controller and the MIPS datapath.
// The controller drives mux selects and enables; the datapath supplies opcode and mem_ready.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemToReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stretches memory states on mem_ready, counts retirements and traps on bad opcodes.
module mips_multicycle_ctrl #(
    parameter int COUNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    mips_multicycle_ctrl_if.master bus,
    output logic                   retire,
    output logic [COUNT_W-1:0]     instr_count,
    output logic                   trap,
    output logic [3:0]             state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // rdy_q marks states whose IRWrite/PCWrite/retire only fire once memory completes.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       retire;
        logic       trap;
        logic       rdy_q;
    } ctrl_t;

    function automatic ctrl_t f_decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.rdy_q     = 1'b1;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
                c.retire    = 1'b1;
                c.rdy_q     = 1'b1;
            end
            S_RTEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_RTWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.retire        = 1'b1;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
                c.retire    = 1'b1;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_TRAP:  c.trap = 1'b1;
            default: c.trap = 1'b1;
        endcase
        return c;
    endfunction

    state_t             r_state;
    ctrl_t              r_ctrl;
    logic [COUNT_W-1:0] r_count;
    state_t             w_next;
    logic               w_rdy_ok;
    logic               w_retire;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (bus.mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     w_next = S_RTEXEC;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default:      w_next = S_TRAP;
                endcase
            end
            // Opcode is sampled again here; anything but lw/sw is treated as corruption.
            S_MEMADR: begin
                if (bus.opcode == OP_LW)      w_next = S_MEMRD;
                else if (bus.opcode == OP_SW) w_next = S_MEMWR;
                else                          w_next = S_TRAP;
            end
            S_MEMRD:  if (bus.mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) w_next = S_FETCH;
            S_RTEXEC: w_next = S_RTWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_RTWB, S_BEQ, S_JUMP, S_ADDIWB: w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_TRAP;
        endcase
    end

    assign w_rdy_ok = bus.mem_ready | ~r_ctrl.rdy_q;
    assign w_retire = r_ctrl.retire & w_rdy_ok;

    // Controls are registered from the next state so each state's decode is ready on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_ctrl  <= f_decode(S_FETCH);
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= f_decode(w_next);
            if (w_retire) r_count <= r_count + COUNT_W'(1);
        end
    end

    // Reset gating is combinational so an abort kills memory strobes immediately.
    assign bus.PCWrite     = rst & r_ctrl.pc_write & w_rdy_ok;
    assign bus.IRWrite     = rst & r_ctrl.ir_write & w_rdy_ok;
    assign bus.PCWriteCond = rst & r_ctrl.pc_write_cond;
    assign bus.IorD        = rst & r_ctrl.iord;
    assign bus.MemRead     = rst & r_ctrl.mem_read;
    assign bus.MemWrite    = rst & r_ctrl.mem_write;
    assign bus.MemToReg    = rst & r_ctrl.mem_to_reg;
    assign bus.RegDst      = rst & r_ctrl.reg_dst;
    assign bus.RegWrite    = rst & r_ctrl.reg_write;
    assign bus.ALUSrcA     = rst & r_ctrl.alu_src_a;
    assign bus.ALUSrcB     = {2{rst}} & r_ctrl.alu_src_b;
    assign bus.ALUOp       = {2{rst}} & r_ctrl.alu_op;
    assign bus.PCSource    = {2{rst}} & r_ctrl.pc_source;
    assign retire          = rst & w_retire;
    assign trap            = rst & r_ctrl.trap;
    assign instr_count     = r_count;
    assign state           = r_state;

endmodule
